rc4_decrypt: RTL and testbench



---
 rtl/rc4_decrypt_if.sv | 28 ++
 rtl/rc4_decrypt.sv | 121 ++++++++++++
 tb/tb_rc4_decrypt.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_decrypt_if.sv
// Control and memory-port bundle for the RC4 PRGA decrypt stage.
// master = decrypt engine; slave = S RAM, encrypted ROM, decrypted RAM and the controller.
interface rc4_decrypt_if;
  logic       start;
  logic       finish;
  logic       invalid;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_q;
  logic [7:0] rom_address;
  logic [7:0] rom_q;
  logic [7:0] dec_address;
  logic [7:0] dec_data;
  logic       dec_wren;

  modport master (
    input  start, s_q, rom_q,
    output finish, invalid, s_address, s_data, s_wren,
           rom_address, dec_address, dec_data, dec_wren
  );

  modport slave (
    output start, s_q, rom_q,
    input  finish, invalid, s_address, s_data, s_wren,
           rom_address, dec_address, dec_data, dec_wren
  );
endinterface

// File: rtl/rc4_decrypt.sv
// RC4 PRGA: permutes S in place and writes keystream ^ ciphertext to the decrypted RAM.
// Optional macro RC4_CHECK_ASCII_EN aborts on the first byte that is not space or 'a'..'z'.
module rc4_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rc4_decrypt_if.master        bus,
  output logic [3:0]           o_dbg_state
);
  localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INC_I, S_WAIT_SI, S_READ_SI, S_WAIT_SJ, S_READ_SJ, S_WRITE_I,
    S_WRITE_J, S_WRITE_END, S_READ_F, S_WAIT_F, S_XOR, S_NEXT, S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_i, r_j, r_k, r_si, r_sj;
  logic [7:0] r_s_address, r_s_data, r_rom_address, r_dec_address, r_dec_data;
  logic       r_s_wren, r_dec_wren, r_finish, r_invalid;
  logic [7:0] w_pt;
  logic       w_reject;

  assign w_pt = bus.s_q ^ bus.rom_q;

`ifdef RC4_CHECK_ASCII_EN
  assign w_reject = !((w_pt == 8'h20) || ((w_pt >= 8'h61) && (w_pt <= 8'h7A)));
`else
  assign w_reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (bus.start) w_state_next = S_INC_I;
      S_INC_I:     w_state_next = S_WAIT_SI;
      S_WAIT_SI:   w_state_next = S_READ_SI;
      S_READ_SI:   w_state_next = S_WAIT_SJ;
      S_WAIT_SJ:   w_state_next = S_READ_SJ;
      S_READ_SJ:   w_state_next = S_WRITE_I;
      S_WRITE_I:   w_state_next = S_WRITE_J;
      S_WRITE_J:   w_state_next = S_WRITE_END;
      S_WRITE_END: w_state_next = S_READ_F;
      S_READ_F:    w_state_next = S_WAIT_F;
      S_WAIT_F:    w_state_next = S_XOR;
      S_XOR:       w_state_next = w_reject ? S_DONE : S_NEXT;
      S_NEXT:      w_state_next = (r_k == K_LAST) ? S_DONE : S_INC_I;
      S_DONE:      if (!bus.start) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Memory q is valid two states after the address is registered, hence the WAIT states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i <= '0; r_j <= '0; r_k <= '0; r_si <= '0; r_sj <= '0;
      r_s_address <= '0; r_s_data <= '0; r_s_wren <= 1'b0;
      r_rom_address <= '0; r_dec_address <= '0; r_dec_data <= '0;
      r_dec_wren <= 1'b0; r_finish <= 1'b0; r_invalid <= 1'b0;
    end else begin
      r_finish <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          r_i <= '0; r_j <= '0; r_k <= '0; r_invalid <= 1'b0;
        end
        S_INC_I: begin
          r_i         <= r_i + 8'd1;
          r_s_address <= r_i + 8'd1;
        end
        S_READ_SI: begin
          r_si        <= bus.s_q;
          r_j         <= r_j + bus.s_q;
          r_s_address <= r_j + bus.s_q;
        end
        S_READ_SJ: r_sj <= bus.s_q;
        S_WRITE_I: begin
          r_s_address <= r_i; r_s_data <= r_sj; r_s_wren <= 1'b1;
        end
        S_WRITE_J: begin
          r_s_address <= r_j; r_s_data <= r_si; r_s_wren <= 1'b1;
        end
        S_WRITE_END: r_s_wren <= 1'b0;
        S_READ_F: begin
          r_s_wren      <= 1'b0;
          r_s_address   <= r_si + r_sj;
          r_rom_address <= r_k;
        end
        S_XOR: begin
          if (w_reject) begin
            r_invalid <= 1'b1;
          end else begin
            r_dec_address <= r_k; r_dec_data <= w_pt; r_dec_wren <= 1'b1;
          end
        end
        S_NEXT: begin
          r_dec_wren <= 1'b0;
          if (r_k != K_LAST) r_k <= r_k + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.finish      = r_finish;
  assign bus.invalid     = r_invalid;
  assign bus.s_address   = r_s_address;
  assign bus.s_data      = r_s_data;
  assign bus.s_wren      = r_s_wren;
  assign bus.rom_address = r_rom_address;
  assign bus.dec_address = r_dec_address;
  assign bus.dec_data    = r_dec_data;
  assign bus.dec_wren    = r_dec_wren;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_rc4_decrypt.sv
// Bench for rc4_decrypt: memory models, software RC4 reference and dec-write scoreboard.
module tb_rc4_decrypt;
  localparam int MSG_LEN = 32;
`ifdef RC4_CHECK_ASCII_EN
  localparam bit ASCII_ON = 1'b1;
`else
  localparam bit ASCII_ON = 1'b0;
`endif
  localparam logic [3:0] ST_IDLE = 4'd0, ST_WRITE_I = 4'd6, ST_DONE = 4'd13;
  localparam int BUDGET = 20000;

  typedef struct {
    bit          use_key;
    logic [23:0] key;
    int          rom_mode;   // 0 constant fill, 1 random, 2 plaintext = fill
    logic [7:0]  fill;
    int          n_hand;
    logic [7:0]  h0, h1, h2;
    int          hand_lat;
    bit          drop_start;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dbg_state;
  rc4_decrypt_if bus();

  rc4_decrypt #(.MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem[256], s_img[256], rom_mem[256], dec_mem[256], m_s[256], ks[256];
  logic [7:0] s_addr_r = 8'd0, rom_addr_r = 8'd0;
  logic       tb_load = 1'b0;

  always @(posedge clk) begin
    s_addr_r   <= bus.s_address;
    rom_addr_r <= bus.rom_address;
    if (tb_load) for (int a = 0; a < 256; a++) s_mem[a] <= s_img[a];
    else if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
    if (bus.dec_wren) dec_mem[bus.dec_address] <= bus.dec_data;
  end
  assign bus.s_q   = s_mem[s_addr_r];
  assign bus.rom_q = rom_mem[rom_addr_r];

  int          n_checks = 0, n_errors = 0;
  logic [15:0] exp_q[$];
  int          m_abort, overlap, n_swr, lat;
  vec_t        tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bus"}, {bus.s_address, bus.s_data, bus.rom_address, bus.dec_address}, 32'd0);
    check({tag, "_ctl"}, {16'd0, bus.dec_data, bus.finish, bus.invalid, bus.s_wren,
                          bus.dec_wren, dbg_state}, {16'd0, 8'd0, 4'd0, ST_IDLE});
  endtask

  task automatic build_s(input bit use_key, input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int a = 0; a < 256; a++) s_img[a] = 8'(a);
    if (use_key) begin
      j = 8'd0;
      for (int a = 0; a < 256; a++) begin
        case (a % 3)
          0:       kb = key[23:16];
          1:       kb = key[15:8];
          default: kb = key[7:0];
        endcase
        j = 8'(j + s_img[a] + kb);
        t = s_img[a]; s_img[a] = s_img[j]; s_img[j] = t;
      end
    end
  endtask

  task automatic model_run(input bit allow_abort, input bit push);
    logic [7:0] i, j, t, f;
    i = 8'd0; j = 8'd0; m_abort = -1;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = 8'(i + 8'd1);
      j = 8'(j + m_s[i]);
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      t = 8'(m_s[i] + m_s[j]);
      ks[k] = m_s[t];
      f = ks[k] ^ rom_mem[k];
      if (allow_abort && ASCII_ON && !(f == 8'h20 || (f >= 8'h61 && f <= 8'h7A))) begin
        m_abort = k;
        break;
      end
      if (push) exp_q.push_back({8'(k), f});
    end
  endtask

  task automatic prepare(input vec_t vc);
    build_s(vc.use_key, vc.key);
    for (int a = 0; a < 256; a++)
      rom_mem[a] = (vc.rom_mode == 1) ? 8'($urandom_range(0, 255)) :
                   (vc.rom_mode == 2) ? 8'h00 : vc.fill;
    if (vc.rom_mode == 2) begin
      for (int a = 0; a < 256; a++) m_s[a] = s_img[a];
      model_run(1'b0, 1'b0);
      for (int k = 0; k < MSG_LEN; k++) rom_mem[k] = ks[k] ^ vc.fill;
    end
    for (int a = 0; a < 256; a++) m_s[a] = s_img[a];
    model_run(1'b1, 1'b1);
    @(negedge clk); tb_load = 1'b1;
    @(negedge clk); tb_load = 1'b0;
  endtask

  task automatic monitor();
    if (bus.s_wren && bus.dec_wren) overlap++;
    if (bus.s_wren) n_swr++;
    if (bus.dec_wren) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dec_write_extra actual=%0h:%0h expected=none", bus.dec_address, bus.dec_data);
      end else begin
        check("dec_write", {16'd0, bus.dec_address, bus.dec_data}, {16'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic do_run(input bit drop_start);
    int n;
    n = 0; overlap = 0; n_swr = 0; lat = -1;
    @(negedge clk); bus.start = 1'b1;
    while (n < BUDGET) begin
      @(posedge clk); n++; #1;
      if (drop_start && n == 3) bus.start = 1'b0;
      monitor();
      if (bus.finish) begin lat = n; break; end
    end
  endtask

  task automatic post_checks(input vec_t vc);
    int mism, exp_lat;
    exp_lat = (m_abort < 0) ? 12 * MSG_LEN + 1 : 12 * m_abort + 12;
    check("latency", lat, exp_lat);
    if (vc.hand_lat != 0) check("latency_hand", lat, vc.hand_lat);
    check("dec_writes_left", exp_q.size(), 0);
    exp_q.delete();
    check("s_wren_cycles", n_swr, 2 * ((m_abort < 0) ? MSG_LEN : m_abort + 1));
    check("wren_overlap", overlap, 0);
    check("invalid", {31'd0, bus.invalid}, {31'd0, m_abort >= 0});
    mism = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) mism++;
    check("s_final", mism, 0);
    if (vc.n_hand > 0) begin
      check("dec_hand0", dec_mem[0], vc.h0);
      check("dec_hand1", dec_mem[1], vc.h1);
      check("dec_hand2", dec_mem[2], vc.h2);
    end
    if (bus.start) begin
      repeat (3) @(posedge clk);
      #1 check("finish_hold", {bus.finish, dbg_state}, {1'b1, ST_DONE});
      @(negedge clk); bus.start = 1'b0;
    end
    @(posedge clk); #1;
    check("finish_drop", {bus.finish, dbg_state}, {1'b0, ST_IDLE});
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int   n, nwi;
`ifdef RC4_CHECK_ASCII_EN
    tbl[0] = '{0, 24'h0, 0, 8'h61, 3, 8'h63, 8'h64, 8'h66, 0, 0};
    tbl[1] = '{0, 24'h0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 12, 0};
    tbl[2] = '{1, 24'h000249, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1};
    tbl[3] = '{1, 24'h000249, 2, 8'h7A, 3, 8'h7A, 8'h7A, 8'h7A, 385, 0};
`else
    tbl[0] = '{0, 24'h0, 0, 8'h00, 3, 8'h02, 8'h05, 8'h07, 385, 0};
    tbl[1] = '{0, 24'h0, 0, 8'hFF, 3, 8'hFD, 8'hFA, 8'hF8, 385, 1};
    tbl[2] = '{1, 24'h000249, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[3] = '{1, 24'h1A2B3C, 2, 8'h20, 3, 8'h20, 8'h20, 8'h20, 385, 1};
`endif
    rv = '{0, 24'h0, 2, 8'h61, 3, 8'h61, 8'h61, 8'h61, 385, 0};

    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      prepare(tbl[v]);
      do_run(tbl[v].drop_start);
      post_checks(tbl[v]);
    end

    // Reset in byte 10's WRITE_I, then a clean rerun.
    prepare(rv);
    n = 0; nwi = 0; overlap = 0; n_swr = 0;
    @(negedge clk); bus.start = 1'b1;
    while (n < BUDGET && nwi < 11) begin
      @(posedge clk); n++; #1;
      monitor();
      if (dbg_state == ST_WRITE_I) nwi++;
    end
    check("reach_byte10", nwi, 11);
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset_mid");
    exp_q.delete();
    bus.start = 1'b0;
    @(negedge clk) reset = 1'b0;
    prepare(rv);
    do_run(1'b0);
    post_checks(rv);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
